fetch_ftq: RTL and testbench
============================

Name: fetch_ftq

Overview:
- IF1/IF2 fetch sequencer sitting directly upstream of the 2-wide predecode stage.
- Owns the fetch PC and issues 8-byte-aligned I-cache requests.
- Applies BTB redirects and tracks in-flight requests in an in-order fetch target queue (FTQ).
- Delivers {instruction pair, PC, exception, BTB info} bundles to predecode, honouring predecode's busy backpressure and pipeline flushes.

Parameters:
- DEPTH, 4, FTQ entries and maximum outstanding-plus-buffered fetches; power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- cpu_clk_i  in  1  clock
- cpu_rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush / redirect
- flush_pc_i  in  32  redirect target
- ic_req_o  out  1  I-cache request valid
- ic_addr_o  out  32  request address, [2:0] forced to 0
- ic_ready_i  in  1  request accepted when ic_req_o&ic_ready_i
- ic_rsp_vld_i  in  1  response valid, in request order, cannot be stalled
- ic_rsp_data_i  in  64  instruction pair
- ic_rsp_excp_vld_i  in  1  fetch fault
- ic_rsp_excp_code_i  in  4  fault cause
- btb_pc_o  out  32  lookup PC (= current fetch PC)
- btb_hit_i  in  1  BTB hit for btb_pc_o, same cycle
- btb_idx_i  in  1  slot of hit branch (0 = PC[2]==0 word)
- btb_way_i  in  1  hit way
- btb_btype_i  in  2  00 cond, 01 indirect, 10 jump, 11 ret
- btb_bm_pred_i  in  2  bimodal counter
- btb_target_i  in  32  predicted target
- valid_o  out  1  bundle valid to predecode
- instr_o  out  64  instruction pair
- vpc_o  out  32  bundle PC (PC[2] marks upper-word start)
- excp_vld_o  out  1  fault valid
- excp_code_o  out  4  fault cause
- btb_vld_o / btb_idx_o / btb_way_o / btb_btype_o / btb_bm_pred_o / btb_target_o  out  1/1/1/2/2/32  BTB info captured at request
- busy_i  in  1  predecode busy; bundle held while high

Behaviour:
- Reset (async, cpu_rst_n_i low):
  - pc=RESET_PC, state=RUN.
  - FTQ head/tail/resp pointers=0, discard=0.
  - valid_o=0, ic_req_o=0; all bundle outputs 0.
- Effective hit: btb_hit_i & !(btb_idx_i==0 & pc[2]==1).
- Taken: effective hit & (btype[1] | bm_pred[1]).
- Issue: ic_req_o = state==RUN & (tail-head)<DEPTH. ic_req_o does not depend on flush_i.
- On accept:
  - Write meta {pc, BTB fields, btb_vld=effective hit} at tail; tail++.
  - pc <= taken ? btb_target_i : {pc[31:3]+1, 3'b0}.
- Response:
  - With discard==0: write data/excp into the entry at resp pointer, mark ready, resp++.
  - With discard!=0: drop the response and decrement discard.
- Output:
  - valid_o = head entry ready; fields are driven from the head entry (no added latency).
  - Dequeue when valid_o & !busy_i.
  - Minimum request-accept to valid_o latency is I-cache latency + 1 cycle.
- HALT state:
  - When an entry with excp_vld is written, state <= HALT.
  - No requests are issued while in HALT; only flush leaves HALT.
- Flush (highest priority):
  - head=tail=resp=0, all ready bits cleared, valid_o=0 the next cycle, pc <= flush_pc_i, state <= RUN.
  - discard <= count of accepted-but-unreturned requests, including one accepted in the flush cycle, excluding one returning in the flush cycle.
  - A response in the flush cycle is dropped.
  - The first request at flush_pc_i is issued the cycle after the flush.
- Full: DEPTH entries allocated → ic_req_o=0. A dequeue and a new accept may occur in the same cycle.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. discard is the same width and saturates at DEPTH by construction.
- ic_rsp_vld_i with no outstanding request is an assertion error.

Decomposition:
- fetch_pkg:
  - btype_t enum (COND, IND, JMP, RET).
  - excp code constants.
  - ftq_meta_t struct {pc, btb_vld, idx, way, btype, bm_pred, target}.
- Sub-module ftq_store: DEPTH-entry register array with separate meta-write, data-write and head-read ports.
- Pointers, discard counter, PC and state live in fetch_ftq.

Test Plan:
- Straight-line fetch:
  - Stimulus: reset, RESET_PC=0x1000, 1-cycle cache, busy_i=0, no BTB hits.
  - Required: ic_addr_o = 0x1000, 0x1008, 0x1010…; bundles in order with vpc_o matching.
- Slot-1 redirect:
  - Stimulus: pc=0x2000, taken hit with btype=10, idx=1, target=0x3004.
  - Required: next ic_addr_o = 0x3000; next vpc_o = 0x3004; btb_vld_o=1 on the 0x2000 bundle.
- Masked slot-0 hit:
  - Stimulus: pc=0x3004, hit with idx=0.
  - Required: treated as a miss; next pc = 0x3008; btb_vld_o=0.
- Backpressure:
  - Stimulus: busy_i=1 for 10 cycles, DEPTH=4.
  - Required: exactly 4 accepts then ic_req_o=0; bundles held stable; order preserved after release.
- Flush with in-flight requests:
  - Stimulus: 3-cycle cache, 3 requests outstanding, flush_i with flush_pc_i=0x8000.
  - Required: 3 stale responses dropped; first bundle has vpc_o=0x8000.
- Fault and halt:
  - Stimulus: response with excp_vld=1, code=4'h1 (or 4'hC).
  - Required: bundle carries the fault; no further requests until flush; reset asserted mid-stream clears valid_o immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its target queue.
package fetch_pkg;

    // BTB branch type, encoding matches btb_btype_i
    typedef enum logic [1:0] {
        BtCond = 2'b00,
        BtInd  = 2'b01,
        BtJmp  = 2'b10,
        BtRet  = 2'b11
    } btype_t;

    // Fetch fault causes reported by the I-cache
    localparam logic [3:0] ExcpNone        = 4'h0;
    localparam logic [3:0] ExcpInstrAccess = 4'h1;
    localparam logic [3:0] ExcpInstrPage   = 4'hC;

    // Request-time metadata captured when the I-cache accepts a fetch
    typedef struct packed {
        logic [31:0] pc;
        logic        btb_vld;
        logic        idx;
        logic        way;
        btype_t      btype;
        logic [1:0]  bm_pred;
        logic [31:0] target;
    } ftq_meta_t;

    // Response payload written when the I-cache returns
    typedef struct packed {
        logic [63:0] instr;
        logic        excp_vld;
        logic [3:0]  excp_code;
    } ftq_data_t;

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_ftq_if.sv
// I-cache, BTB, flush and predecode signals of the fetch sequencer.
interface fetch_ftq_if;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        ic_req_o;
    logic [31:0] ic_addr_o;
    logic        ic_ready_i;
    logic        ic_rsp_vld_i;
    logic [63:0] ic_rsp_data_i;
    logic        ic_rsp_excp_vld_i;
    logic [3:0]  ic_rsp_excp_code_i;
    logic [31:0] btb_pc_o;
    logic        btb_hit_i;
    logic        btb_idx_i;
    logic        btb_way_i;
    logic [1:0]  btb_btype_i;
    logic [1:0]  btb_bm_pred_i;
    logic [31:0] btb_target_i;
    logic        valid_o;
    logic [63:0] instr_o;
    logic [31:0] vpc_o;
    logic        excp_vld_o;
    logic [3:0]  excp_code_o;
    logic        btb_vld_o;
    logic        btb_idx_o;
    logic        btb_way_o;
    logic [1:0]  btb_btype_o;
    logic [1:0]  btb_bm_pred_o;
    logic [31:0] btb_target_o;
    logic        busy_i;

    // Fetch sequencer side
    modport master (
        input  flush_i, flush_pc_i, ic_ready_i, ic_rsp_vld_i, ic_rsp_data_i,
        input  ic_rsp_excp_vld_i, ic_rsp_excp_code_i, btb_hit_i, btb_idx_i, btb_way_i,
        input  btb_btype_i, btb_bm_pred_i, btb_target_i, busy_i,
        output ic_req_o, ic_addr_o, btb_pc_o, valid_o, instr_o, vpc_o, excp_vld_o,
        output excp_code_o, btb_vld_o, btb_idx_o, btb_way_o, btb_btype_o, btb_bm_pred_o,
        output btb_target_o
    );

    // Environment side (I-cache, BTB, predecode, flush source)
    modport slave (
        output flush_i, flush_pc_i, ic_ready_i, ic_rsp_vld_i, ic_rsp_data_i,
        output ic_rsp_excp_vld_i, ic_rsp_excp_code_i, btb_hit_i, btb_idx_i, btb_way_i,
        output btb_btype_i, btb_bm_pred_i, btb_target_i, busy_i,
        input  ic_req_o, ic_addr_o, btb_pc_o, valid_o, instr_o, vpc_o, excp_vld_o,
        input  excp_code_o, btb_vld_o, btb_idx_o, btb_way_o, btb_btype_o, btb_bm_pred_o,
        input  btb_target_o
    );
endinterface

// File: rtl/ftq_store.sv
// FTQ entry storage: meta written at request, data at response, head read combinationally.
module ftq_store
    import fetch_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            meta_we,
    input  logic [AW-1:0]   meta_idx,
    input  ftq_meta_t       meta_wdata,
    input  logic            data_we,
    input  logic [AW-1:0]   data_idx,
    input  ftq_data_t       data_wdata,
    input  logic [AW-1:0]   rd_idx,
    output ftq_meta_t       rd_meta,
    output ftq_data_t       rd_data
);
    ftq_meta_t meta_q [DEPTH];
    ftq_data_t data_q [DEPTH];

    // Entries clear on reset so the bundle outputs read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                meta_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (meta_we) meta_q[meta_idx] <= meta_wdata;
            if (data_we) data_q[data_idx] <= data_wdata;
        end
    end

    assign rd_meta = meta_q[rd_idx];
    assign rd_data = data_q[rd_idx];
endmodule

// File: rtl/fetch_ftq.sv
// IF1/IF2 fetch sequencer: owns the fetch PC, applies BTB redirects and
// keeps in-flight I-cache requests in order until predecode consumes them.
module fetch_ftq
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic         cpu_clk_i,
    input logic         cpu_rst_n_i,
    fetch_ftq_if.master bus
);
    localparam int unsigned   AW     = $clog2(DEPTH);
    localparam int unsigned   PW     = AW + 1;
    localparam logic [PW-1:0] DepthP = PW'(DEPTH);

    logic [PW-1:0]    head_q, tail_q, resp_q, discard_q;
    logic [PW-1:0]    count, outstanding, discard_flush;
    logic [DEPTH-1:0] rdy_q, rdy_d;
    logic [31:0]      pc_q, pc_d;
    state_t           state_q, state_d;
    logic             eff_hit, taken, req, accept, rsp_take, rsp_drop, valid, deq;
    ftq_meta_t        wr_meta, rd_meta;
    ftq_data_t        wr_data, rd_data;

    // Handshake decode; a slot-0 hit is meaningless when fetch starts at the upper word
    always_comb begin
        count         = tail_q - head_q;
        outstanding   = discard_q + (tail_q - resp_q);
        eff_hit       = bus.btb_hit_i & ~(~bus.btb_idx_i & pc_q[2]);
        taken         = eff_hit & (bus.btb_btype_i[1] | bus.btb_bm_pred_i[1]);
        req           = cpu_rst_n_i & (state_q == StRun) & (count < DepthP);
        accept        = req & bus.ic_ready_i;
        rsp_take      = bus.ic_rsp_vld_i & ~bus.flush_i & (discard_q == '0);
        rsp_drop      = bus.ic_rsp_vld_i & ~bus.flush_i & (discard_q != '0);
        valid         = rdy_q[head_q[AW-1:0]];
        deq           = valid & ~bus.busy_i & ~bus.flush_i;
        // Everything still owed by the cache after this edge must be thrown away
        discard_flush = outstanding + PW'(accept) - PW'(bus.ic_rsp_vld_i);
    end

    // Entry contents for the meta and data write ports
    always_comb begin
        wr_meta.pc        = pc_q;
        wr_meta.btb_vld   = eff_hit;
        wr_meta.idx       = bus.btb_idx_i;
        wr_meta.way       = bus.btb_way_i;
        wr_meta.btype     = btype_t'(bus.btb_btype_i);
        wr_meta.bm_pred   = bus.btb_bm_pred_i;
        wr_meta.target    = bus.btb_target_i;
        wr_data.instr     = bus.ic_rsp_data_i;
        wr_data.excp_vld  = bus.ic_rsp_excp_vld_i;
        wr_data.excp_code = bus.ic_rsp_excp_code_i;
    end

    // Ready bits: set on returned data, cleared on dequeue, wiped by flush
    always_comb begin
        rdy_d = rdy_q;
        if (rsp_take) rdy_d[resp_q[AW-1:0]] = 1'b1;
        if (deq)      rdy_d[head_q[AW-1:0]] = 1'b0;
        if (bus.flush_i) rdy_d = '0;
    end

    // Next fetch PC and run/halt state; flush overrides everything
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (rsp_take && bus.ic_rsp_excp_vld_i) state_d = StHalt;
        if (accept) pc_d = taken ? bus.btb_target_i : {pc_q[31:3] + 29'd1, 3'b000};
        if (bus.flush_i) begin
            state_d = StRun;
            pc_d    = bus.flush_pc_i;
        end
    end

    // Queue pointers and stale-response counter
    always_ff @(posedge cpu_clk_i or negedge cpu_rst_n_i) begin
        if (!cpu_rst_n_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            resp_q    <= '0;
            discard_q <= '0;
        end else if (bus.flush_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            resp_q    <= '0;
            discard_q <= discard_flush;
        end else begin
            if (accept)   tail_q    <= tail_q + PW'(1);
            if (rsp_take) resp_q    <= resp_q + PW'(1);
            if (rsp_drop) discard_q <= discard_q - PW'(1);
            if (deq)      head_q    <= head_q + PW'(1);
        end
    end

    // Ready bits, fetch PC and state registers
    always_ff @(posedge cpu_clk_i or negedge cpu_rst_n_i) begin
        if (!cpu_rst_n_i) begin
            rdy_q   <= '0;
            pc_q    <= RESET_PC;
            state_q <= StRun;
        end else begin
            rdy_q   <= rdy_d;
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    ftq_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk        (cpu_clk_i),
        .rst_n      (cpu_rst_n_i),
        .meta_we    (accept & ~bus.flush_i),
        .meta_idx   (tail_q[AW-1:0]),
        .meta_wdata (wr_meta),
        .data_we    (rsp_take),
        .data_idx   (resp_q[AW-1:0]),
        .data_wdata (wr_data),
        .rd_idx     (head_q[AW-1:0]),
        .rd_meta    (rd_meta),
        .rd_data    (rd_data)
    );

    assign bus.ic_req_o      = req;
    assign bus.ic_addr_o     = {pc_q[31:3], 3'b000};
    assign bus.btb_pc_o      = pc_q;
    assign bus.valid_o       = valid;
    assign bus.instr_o       = rd_data.instr;
    assign bus.vpc_o         = rd_meta.pc;
    assign bus.excp_vld_o    = rd_data.excp_vld;
    assign bus.excp_code_o   = rd_data.excp_code;
    assign bus.btb_vld_o     = rd_meta.btb_vld;
    assign bus.btb_idx_o     = rd_meta.idx;
    assign bus.btb_way_o     = rd_meta.way;
    assign bus.btb_btype_o   = rd_meta.btype;
    assign bus.btb_bm_pred_o = rd_meta.bm_pred;
    assign bus.btb_target_o  = rd_meta.target;

    // The cache never answers a request that was not made
    assert property (@(posedge cpu_clk_i) disable iff (!cpu_rst_n_i)
                     !(bus.ic_rsp_vld_i && (outstanding == '0)));
endmodule

// File: tb/tb_fetch_ftq.sv
// Randomized bench for fetch_ftq: in-order cache model, transaction-level
// expectation queue and a separate output monitor.
module tb_fetch_ftq;
    import fetch_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fetch_ftq_if bus ();

    fetch_ftq #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .cpu_clk_i   (clk),
        .cpu_rst_n_i (rst_n),
        .bus         (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        btb_vld;
        logic        idx;
        logic        way;
        logic [1:0]  btype;
        logic [1:0]  bm;
        logic [31:0] target;
        logic [63:0] data;
        logic        excp;
        logic [3:0]  code;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        logic        excp;
        logic [3:0]  code;
        int          due;
        bit          stale;
    } pend_t;

    exp_t        exp_q[$];   // accepted, not yet consumed bundles of the live stream
    pend_t       pend_q[$];  // requests the cache still owes a response for
    int          n_ret, pend_ret;
    bit          halt, pend_halt;
    int          checks, errors, cyc, accepts;
    logic [31:0] mpc;

    int          lat, rdy_pct, busy_pct, hit_pct, excp_pct, flush_pct;
    bit          rules_on, excp_next, flush_req;
    logic [3:0]  excp_next_code;
    logic [31:0] flush_pc_req;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic idle_inputs();
        bus.flush_i = 1'b0;            bus.flush_pc_i = '0;
        bus.ic_ready_i = 1'b0;         bus.ic_rsp_vld_i = 1'b0;
        bus.ic_rsp_data_i = '0;        bus.ic_rsp_excp_vld_i = 1'b0;
        bus.ic_rsp_excp_code_i = '0;   bus.btb_hit_i = 1'b0;
        bus.btb_idx_i = 1'b0;          bus.btb_way_i = 1'b0;
        bus.btb_btype_i = '0;          bus.btb_bm_pred_i = '0;
        bus.btb_target_i = '0;         bus.busy_i = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_q.delete();
        n_ret = 0; pend_ret = 0; halt = 0; pend_halt = 0;
        mpc = RST_PC;
    endtask

    // One clock of stimulus: check issue side, then drive cache, BTB, busy and flush
    task automatic cycle();
        bit          flush, ready, exp_req, eff, taken, hit, idx, way;
        logic [1:0]  btype, bm;
        logic [31:0] target, fpc;
        pend_t       p;
        @(negedge clk);
        cyc++;
        n_ret += pend_ret;
        pend_ret = 0;
        if (pend_halt) halt = 1;
        pend_halt = 0;

        exp_req = !halt && (exp_q.size() < DEPTH);
        chk("ic_req_o", bus.ic_req_o, exp_req);
        chk("btb_pc_o", bus.btb_pc_o, mpc);
        if (exp_req) chk("ic_addr_o", bus.ic_addr_o, {mpc[31:3], 3'b000});

        flush = flush_req || ($urandom_range(99) < flush_pct);
        fpc   = flush_req ? flush_pc_req : 32'($urandom_range(16'hffff)) << 2;
        bus.flush_i    = flush;
        bus.flush_pc_i = fpc;
        bus.busy_i     = $urandom_range(99) < busy_pct;

        // In-order cache response
        bus.ic_rsp_vld_i = 1'b0;
        bus.ic_rsp_data_i = {$urandom, $urandom};
        bus.ic_rsp_excp_vld_i = 1'b0;
        bus.ic_rsp_excp_code_i = '0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            bus.ic_rsp_vld_i       = 1'b1;
            bus.ic_rsp_data_i      = p.data;
            bus.ic_rsp_excp_vld_i  = p.excp;
            bus.ic_rsp_excp_code_i = p.code;
            if (!p.stale && !flush) begin
                pend_ret++;
                if (p.excp) pend_halt = 1;
            end
        end
        ready = ($urandom_range(99) < rdy_pct) && (pend_q.size() < DEPTH);
        bus.ic_ready_i = ready;

        // BTB lookup for the model PC
        hit = $urandom_range(99) < hit_pct;
        idx = 1'($urandom); way = 1'($urandom);
        btype = 2'($urandom); bm = 2'($urandom);
        target = {16'h0, 16'($urandom)};
        if (rules_on && mpc == 32'h2000) begin
            hit = 1; idx = 1; btype = 2'b10; bm = 2'b00; target = 32'h3004;
        end else if (rules_on && mpc == 32'h3004) begin
            hit = 1; idx = 0; btype = 2'b00; bm = 2'b11; target = 32'h5000;
        end
        bus.btb_hit_i = hit;       bus.btb_idx_i = idx;      bus.btb_way_i = way;
        bus.btb_btype_i = btype;   bus.btb_bm_pred_i = bm;   bus.btb_target_i = target;

        eff   = hit && !(idx == 1'b0 && mpc[2]);
        taken = eff && (btype[1] || bm[1]);

        if (bus.ic_req_o && ready) begin
            p.data  = {$urandom, $urandom};
            p.excp  = excp_next || ($urandom_range(99) < excp_pct);
            p.code  = excp_next ? excp_next_code :
                      (p.excp ? ($urandom_range(1) ? ExcpInstrPage : ExcpInstrAccess) : ExcpNone);
            p.due   = cyc + lat;
            p.stale = flush;
            pend_q.push_back(p);
            if (!flush) begin
                exp_q.push_back('{pc: mpc, btb_vld: eff, idx: idx, way: way, btype: btype,
                                  bm: bm, target: target, data: p.data, excp: p.excp,
                                  code: p.code});
                mpc = taken ? target : {mpc[31:3] + 29'd1, 3'b000};
                excp_next = 0;
                accepts++;
            end
        end
        if (flush) begin
            foreach (pend_q[i]) pend_q[i].stale = 1;
            mpc = fpc;
            halt = 0;
            pend_halt = 0;
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_flush(logic [31:0] pc);
        flush_req = 1; flush_pc_req = pc;
        cycle();
        flush_req = 0;
    endtask

    // Output monitor: compares the head bundle, retires it on a completed handshake
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                chk("valid_o", bus.valid_o, n_ret > 0);
                if (n_ret > 0 && bus.valid_o && exp_q.size() > 0) begin
                    chk("vpc_o", bus.vpc_o, exp_q[0].pc);
                    chk("instr_o", bus.instr_o, exp_q[0].data);
                    chk("excp", {bus.excp_vld_o, bus.excp_code_o},
                        {exp_q[0].excp, exp_q[0].code});
                    chk("btb_info", {bus.btb_vld_o, bus.btb_idx_o, bus.btb_way_o,
                                     bus.btb_btype_o, bus.btb_bm_pred_o, bus.btb_target_o},
                        {exp_q[0].btb_vld, exp_q[0].idx, exp_q[0].way, exp_q[0].btype,
                         exp_q[0].bm, exp_q[0].target});
                end
                if (bus.flush_i) begin
                    exp_q.delete();
                    n_ret = 0;
                end else if (n_ret > 0 && !bus.busy_i && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    n_ret--;
                end
            end
        end
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; accepts = 0;
        lat = 1; rdy_pct = 100; busy_pct = 0; hit_pct = 0; excp_pct = 0; flush_pct = 0;
        rules_on = 0; excp_next = 0; excp_next_code = '0; flush_req = 0; flush_pc_req = '0;
        idle_inputs();
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid_o", bus.valid_o, 1'b0);
        chk("rst_ic_req_o", bus.ic_req_o, 1'b0);
        chk("rst_bundle", {bus.instr_o, bus.vpc_o, bus.excp_vld_o, bus.btb_vld_o}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fetch from the reset PC
        run(20);

        // Slot-1 taken redirect at 0x2000, then masked slot-0 hit at 0x3004
        rules_on = 1;
        do_flush(32'h2000);
        run(15);
        rules_on = 0;

        // Backpressure: only DEPTH requests may be accepted while predecode is busy
        busy_pct = 100;
        do_flush(32'h4000);
        accepts = 0;
        run(10);
        chk("bp_accepts", accepts, DEPTH);
        busy_pct = 0;
        run(15);

        // Flush with three requests in flight on a 3-cycle cache
        lat = 3;
        do_flush(32'h6000);
        run(3);
        do_flush(32'h8000);
        run(20);

        // Fault halts fetch; bundle stays held under busy; reset clears it at once
        lat = 1; busy_pct = 100; excp_next = 1; excp_next_code = ExcpInstrPage;
        do_flush(32'h9000);
        run(10);
        #2;
        chk("halt_valid_held", bus.valid_o, 1'b1);
        chk("halt_excp_head", {bus.excp_vld_o, bus.excp_code_o}, {1'b1, ExcpInstrPage});
        chk("halt_no_req", bus.ic_req_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("midrst_valid_o", bus.valid_o, 1'b0);
        chk("midrst_ic_req_o", bus.ic_req_o, 1'b0);
        chk("midrst_vpc_o", bus.vpc_o, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        busy_pct = 0;
        run(10);

        // Randomized traffic
        for (int s = 0; s < 15; s++) begin
            lat = $urandom_range(4, 1);
            rdy_pct = $urandom_range(100, 40);
            busy_pct = $urandom_range(60);
            hit_pct = 30; excp_pct = 2; flush_pct = 3;
            run(200);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
